branch_sequencer: RTL

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
//
// Decides where the next PC comes from for a small pipelined core. It
// arbitrates between reset, interrupt acceptance and the branch decision of
// the instruction in EX, and it keeps Flush asserted for FLUSH_CYCLES cycles
// after every redirect.
//
// Ports
//   Clk           in   single clock, rising edge
//   Reset         in   synchronous, active-high reset
//   ID_EX_Opcode  in   [3:0] opcode of the instruction in EX
//   ID_EX_Rs_Addr in   [1:0] sub-opcode / flag selector
//   CCR           in   [3:0] flags {V,C,N,Z}, Z in bit 0
//   Branch_en     in   EX instruction is a valid branch
//   Irq           in   [N_IRQ-1:0] level interrupt requests (rising edges latched)
//   Irq_Mask      in   [N_IRQ-1:0] 1 = channel masked
//   PCSrc         out  [1:0] 00 PC+1, 01 branch target, 10 instruction-memory word
//   inst_mem_src  out  [1:0] 0 none, 1 reset vector, 2 interrupt vector, 3 stack
//   Flush         out  flush IF/ID and ID/EX
//   Irq_Id        out  [IW-1:0] index of the last accepted interrupt
//   Irq_Ack       out  [N_IRQ-1:0] one-hot acceptance pulse
//   In_Isr        out  registered "inside an interrupt service routine" flag
// ---------------------------------------------------------------------------
module branch_sequencer #(
  parameter int N_IRQ        = 4,
  parameter int FLUSH_CYCLES = 2,
  localparam int IW          = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       ID_EX_Opcode,
  input  logic [1:0]       ID_EX_Rs_Addr,
  input  logic [3:0]       CCR,
  input  logic             Branch_en,
  input  logic [N_IRQ-1:0] Irq,
  input  logic [N_IRQ-1:0] Irq_Mask,
  output logic [1:0]       PCSrc,
  output logic [1:0]       inst_mem_src,
  output logic             Flush,
  output logic [IW-1:0]    Irq_Id,
  output logic [N_IRQ-1:0] Irq_Ack,
  output logic             In_Isr
);

  typedef enum logic {IDLE, HOLD} state_e;

  // Cycles spent in HOLD after the redirect cycle itself
  localparam logic [2:0] HOLD_INIT = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       hcnt_q, hcnt_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irqDly_q;
  logic [IW-1:0]    irqId_q, irqId_d;
  logic             inIsr_q, inIsr_d;

  logic [N_IRQ-1:0] eligible;
  logic             accept;
  logic [IW-1:0]    ackIdx;
  logic [N_IRQ-1:0] ackVec;
  logic             isBranch;

  assign Irq_Id = irqId_q;
  assign In_Isr = inIsr_q;

  // Pick the lowest-index unmasked pending channel; acceptance is only
  // possible outside an ISR.
  always_comb begin
    eligible = pending_q & ~Irq_Mask;
    accept   = ~inIsr_q & (|eligible);
    ackIdx   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        ackIdx = IW'(i);
      end
    end
    ackVec = N_IRQ'(1) << ackIdx;
  end

  assign isBranch = (ID_EX_Opcode[3:2] == 2'b10) && Branch_en;

  // Output decode and next-state. Reset overrides everything, HOLD only
  // flushes and counts down, IDLE arbitrates interrupt over branch. Every
  // redirect funnels through 'redirect' so the HOLD entry lives in one place.
  always_comb begin
    logic redirect;
    PCSrc        = 2'b00;
    inst_mem_src = 2'd0;
    Flush        = 1'b0;
    Irq_Ack      = '0;
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    irqId_d      = irqId_q;
    inIsr_d      = inIsr_q;
    redirect     = 1'b0;

    if (Reset) begin
      PCSrc        = 2'b10;
      inst_mem_src = 2'd1;
      Flush        = 1'b1;
    end else if (state_q == HOLD) begin
      Flush  = 1'b1;
      hcnt_d = hcnt_q - 3'd1;
      if (hcnt_q == 3'd1) begin
        state_d = IDLE;
      end
    end else if (accept) begin
      PCSrc        = 2'b10;
      inst_mem_src = 2'd2;
      Flush        = 1'b1;
      Irq_Ack      = ackVec;
      irqId_d      = ackIdx;
      inIsr_d      = 1'b1;
      redirect     = 1'b1;
    end else if (isBranch) begin
      case (ID_EX_Opcode[1:0])
        2'b01: begin
          if (CCR[ID_EX_Rs_Addr]) begin
            PCSrc    = 2'b01;
            Flush    = 1'b1;
            redirect = 1'b1;
          end
        end
        2'b10: begin
          if (!CCR[0]) begin
            PCSrc    = 2'b01;
            Flush    = 1'b1;
            redirect = 1'b1;
          end
        end
        2'b11: begin
          if (!ID_EX_Rs_Addr[1]) begin
            PCSrc    = 2'b01;
            Flush    = 1'b1;
            redirect = 1'b1;
          end else begin
            // RET / RTI: return address comes from the stack; only RTI
            // leaves the ISR.
            PCSrc        = 2'b10;
            inst_mem_src = 2'd3;
            Flush        = 1'b1;
            redirect     = 1'b1;
            if (ID_EX_Rs_Addr[0]) begin
              inIsr_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    if (redirect && (FLUSH_CYCLES > 1)) begin
      state_d = HOLD;
      hcnt_d  = HOLD_INIT;
    end
  end

  // New rising edges are latched even while acceptance is blocked; a set in
  // the same cycle as an acknowledge wins so no edge is lost.
  assign pending_d = (pending_q & ~Irq_Ack) | (Irq & ~irqDly_q);

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      hcnt_q    <= 3'd0;
      pending_q <= '0;
      irqDly_q  <= '0;
      irqId_q   <= '0;
      inIsr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      pending_q <= pending_d;
      irqDly_q  <= Irq;
      irqId_q   <= irqId_d;
      inIsr_q   <= inIsr_d;
    end
  end

endmodule
